rx_fifo_ctrl: RTL and testbench

- Pointer and flag controller that sequences the RX FIFO storage array (dual-address, 1-cycle registered read, write/read gated by full/not-empty).
- Accepts push/pop requests from the RX datapath and consumer, and generates the write/read enables, write/read addresses and fifofull/notempty flags that drive the array.
- Adds occupancy count, almost-full/almost-empty thresholds, read-data-valid alignment, flush, and sticky overflow/underflow error flags.

---
 rtl/rx_fifo_ctrl_if.sv | 38 +++
 rtl/rx_fifo_ctrl.sv | 96 +++++++++
 tb/tb_rx_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_fifo_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_fifo_ctrl_if : request/flag bundle between RX FIFO users and control  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface rx_fifo_ctrl_if #(
  parameter int ADDRBIT = 5
);
  logic               push;
  logic               pop;
  logic               flush;
  logic               clr_err;
  logic               write_en;
  logic               read_en;
  logic [ADDRBIT-1:0] wraddr;
  logic [ADDRBIT-1:0] rdaddr;
  logic               fifofull;
  logic               notempty;
  logic               almost_full;
  logic               almost_empty;
  logic [ADDRBIT:0]   count;
  logic               rd_valid;
  logic               overflow;
  logic               underflow;

  modport master (
    output push, pop, flush, clr_err,
    input  write_en, read_en, wraddr, rdaddr, fifofull, notempty,
           almost_full, almost_empty, count, rd_valid, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clr_err,
    output write_en, read_en, wraddr, rdaddr, fifofull, notempty,
           almost_full, almost_empty, count, rd_valid, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/rx_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_fifo_ctrl : pointer, occupancy and flag controller for the RX FIFO    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rx_fifo_ctrl #(
  parameter int ADDRBIT       = 5,
  parameter int FIFO_DEPTH    = 32,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 4
) (
  input  wire                 clk,
  input  wire                 rst,
  rx_fifo_ctrl_if.slave       bus
);

  localparam logic [ADDRBIT:0]   C_DEPTH   = FIFO_DEPTH[ADDRBIT:0];
  localparam logic [ADDRBIT:0]   C_AFULL   = AFULL_THRESH[ADDRBIT:0];
  localparam logic [ADDRBIT:0]   C_AEMPTY  = AEMPTY_THRESH[ADDRBIT:0];
  localparam logic [ADDRBIT:0]   C_CNT_ONE = {{ADDRBIT{1'b0}}, 1'b1};
  localparam logic [ADDRBIT-1:0] C_PTR_ONE = {{(ADDRBIT-1){1'b0}}, 1'b1};

  logic [ADDRBIT-1:0] wraddr_q, wraddr_d;
  logic [ADDRBIT-1:0] rdaddr_q, rdaddr_d;
  logic [ADDRBIT:0]   count_q, count_d;
  logic               rd_valid_q, rd_valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic w_full, w_notempty, w_wr, w_rd;

  // Flags decode only registered count, so they move strictly on clock edges.
  assign w_full     = (count_q == C_DEPTH);
  assign w_notempty = (count_q != '0);
  assign w_wr       = bus.push & ~w_full & ~bus.flush;
  assign w_rd       = bus.pop & w_notempty & ~bus.flush;

  always_comb begin
    wraddr_d    = wraddr_q;
    rdaddr_d    = rdaddr_q;
    count_d     = count_q;
    rd_valid_d  = w_rd;
    overflow_d  = (overflow_q & ~bus.clr_err) | (bus.push & w_full & ~bus.flush);
    underflow_d = (underflow_q & ~bus.clr_err) | (bus.pop & ~w_notempty & ~bus.flush);

    // Depth is a power of two, so pointer wrap is natural binary rollover.
    if (w_wr) wraddr_d = wraddr_q + C_PTR_ONE;
    if (w_rd) rdaddr_d = rdaddr_q + C_PTR_ONE;

    case ({w_wr, w_rd})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    if (bus.flush) begin
      wraddr_d   = '0;
      rdaddr_d   = '0;
      count_d    = '0;
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wraddr_q    <= '0;
      rdaddr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wraddr_q    <= wraddr_d;
      rdaddr_q    <= rdaddr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.write_en     = w_wr;
  assign bus.read_en      = w_rd;
  assign bus.wraddr       = wraddr_q;
  assign bus.rdaddr       = rdaddr_q;
  assign bus.fifofull     = w_full;
  assign bus.notempty     = w_notempty;
  assign bus.almost_full  = (count_q >= C_AFULL);
  assign bus.almost_empty = (count_q <= C_AEMPTY);
  assign bus.count        = count_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rx_fifo_ctrl : directed self-checking bench for rx_fifo_ctrl          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rx_fifo_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [0:31];
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [15:0] exp_q [$];
  logic [15:0] exp_d;

  rx_fifo_ctrl_if #(.ADDRBIT(5)) bus ();

  rx_fifo_ctrl #(
    .ADDRBIT(5), .FIFO_DEPTH(32), .AFULL_THRESH(28), .AEMPTY_THRESH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Storage array the controller sequences: registered read on read_en.
  always @(posedge clk) begin
    if (bus.write_en) mem[bus.wraddr] <= wdata;
    if (bus.read_en)  rdata <= mem[bus.rdaddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [15:0] base);
    bus.push = 1'b1;
    for (int i = 0; i < n; i++) begin
      wdata = base + 16'(i);
      exp_q.push_back(wdata);
      tick();
    end
    bus.push = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    wdata = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_wraddr", bus.wraddr, 0);
    check("rst_rdaddr", bus.rdaddr, 0);
    check("rst_count", bus.count, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_underflow", bus.underflow, 0);
    check("rst_fifofull", bus.fifofull, 0);
    check("rst_notempty", bus.notempty, 0);
    check("rst_almost_full", bus.almost_full, 0);
    check("rst_almost_empty", bus.almost_empty, 1);

    // 32 pushes to full, then a rejected 33rd push
    bus.push = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wdata = 16'(i);
      exp_q.push_back(wdata);
      #1;
      check("fill_write_en", bus.write_en, 1);
      check("fill_wraddr", bus.wraddr, i);
      tick();
      check("fill_count", bus.count, i + 1);
      check("fill_almost_full", bus.almost_full, (i + 1 >= 28) ? 1 : 0);
      check("fill_almost_empty", bus.almost_empty, (i + 1 <= 4) ? 1 : 0);
    end
    check("full_wraddr_wrap", bus.wraddr, 0);
    check("full_fifofull", bus.fifofull, 1);
    wdata = 16'h0BAD;
    #1;
    check("full_write_en", bus.write_en, 0);
    tick();
    check("full_overflow", bus.overflow, 1);
    check("full_count_hold", bus.count, 32);
    bus.push = 1'b0;

    // 32 pops draining in order, then a rejected 33rd pop
    bus.pop = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("drain_read_en", bus.read_en, 1);
      check("drain_rdaddr", bus.rdaddr, i);
      tick();
      exp_d = exp_q.pop_front();
      check("drain_rd_valid", bus.rd_valid, 1);
      check("drain_data", rdata, i);
      check("drain_count", bus.count, 31 - i);
    end
    check("empty_notempty", bus.notempty, 0);
    #1;
    check("empty_read_en", bus.read_en, 0);
    tick();
    check("empty_underflow", bus.underflow, 1);
    check("empty_rd_valid", bus.rd_valid, 0);
    bus.pop = 1'b0;
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("clr_overflow", bus.overflow, 0);
    check("clr_underflow", bus.underflow, 0);

    // Steady-state streaming at count 10 across pointer wraps
    fill(10, 16'h0100);
    check("stream_count0", bus.count, 10);
    bus.push = 1'b1; bus.pop = 1'b1;
    for (int k = 0; k < 50; k++) begin
      wdata = 16'h0200 + 16'(k);
      exp_q.push_back(wdata);
      tick();
      exp_d = exp_q.pop_front();
      check("stream_count", bus.count, 10);
      check("stream_rd_valid", bus.rd_valid, 1);
      check("stream_data", rdata, exp_d);
    end
    check("stream_wraddr", bus.wraddr, 28);
    check("stream_rdaddr", bus.rdaddr, 18);
    bus.push = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_d = exp_q.pop_front();
      check("stream_tail_data", rdata, exp_d);
    end
    bus.pop = 1'b0;
    check("stream_empty", bus.count, 0);

    // Full with push+pop: only the read is accepted
    fill(32, 16'h0300);
    bus.push = 1'b1; bus.pop = 1'b1;
    #1;
    check("fullpp_write_en", bus.write_en, 0);
    check("fullpp_read_en", bus.read_en, 1);
    tick();
    check("fullpp_count", bus.count, 31);
    check("fullpp_overflow", bus.overflow, 1);
    bus.push = 1'b0;
    for (int k = 0; k < 31; k++) tick();
    bus.pop = 1'b0;
    exp_q.delete();
    check("fullpp_drained", bus.count, 0);

    // Empty with push+pop: only the write is accepted
    bus.push = 1'b1; bus.pop = 1'b1;
    #1;
    check("emptypp_write_en", bus.write_en, 1);
    check("emptypp_read_en", bus.read_en, 0);
    tick();
    bus.push = 1'b0; bus.pop = 1'b0;
    check("emptypp_count", bus.count, 1);
    check("emptypp_rd_valid", bus.rd_valid, 0);
    check("emptypp_underflow", bus.underflow, 1);

    // Flush at count 17 with pop active; sticky errors survive
    fill(16, 16'h0400);
    check("preflush_count", bus.count, 17);
    bus.pop = 1'b1; bus.flush = 1'b1;
    #1;
    check("flush_read_en", bus.read_en, 0);
    tick();
    bus.pop = 1'b0; bus.flush = 1'b0;
    check("flush_count", bus.count, 0);
    check("flush_wraddr", bus.wraddr, 0);
    check("flush_rdaddr", bus.rdaddr, 0);
    check("flush_rd_valid", bus.rd_valid, 0);
    check("flush_almost_empty", bus.almost_empty, 1);
    check("flush_keeps_overflow", bus.overflow, 1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("clr_after_flush", bus.overflow, 0);
    fill(32, 16'h0500);
    bus.push = 1'b1; bus.clr_err = 1'b1;
    tick();
    bus.push = 1'b0; bus.clr_err = 1'b0;
    check("set_beats_clr", bus.overflow, 1);

    // Reset mid-stream at count 20 with push active
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    exp_q.delete();
    fill(20, 16'h0600);
    check("prerst_count", bus.count, 20);
    bus.push = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; bus.push = 1'b0;
    check("midrst_count", bus.count, 0);
    check("midrst_wraddr", bus.wraddr, 0);
    check("midrst_rdaddr", bus.rdaddr, 0);
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_overflow", bus.overflow, 0);
    check("midrst_underflow", bus.underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
